// File: rtl/aes_key_expand_pkg.sv
// Shared AES definitions: word type, default round count and the round-constant table.
package aes_key_expand_pkg;

  typedef logic [31:0] aes_word_t;

  localparam int NR_DEFAULT = 10;

  // Rcon[1..10] stored at positions 0..9
  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    r = 8'h00;
    if (i >= 4'd1 && i <= 4'd10) r = RCON[i - 4'd1];
    return r;
  endfunction

endpackage

// File: rtl/aes_key_expand_sbox.sv
// Combinational AES S-box: GF(2^8) inverse (as x^254) followed by the affine map.
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127, inv;

  // Addition chain to x^254, which is the multiplicative inverse (and maps 0 to 0)
  always_comb begin
    x2   = gf_mul(din, din);
    x3   = gf_mul(x2, din);
    x6   = gf_mul(x3, x3);
    x7   = gf_mul(x6, din);
    x14  = gf_mul(x7, x7);
    x15  = gf_mul(x14, din);
    x30  = gf_mul(x15, x15);
    x31  = gf_mul(x30, din);
    x62  = gf_mul(x31, x31);
    x63  = gf_mul(x62, din);
    x126 = gf_mul(x63, x63);
    x127 = gf_mul(x126, din);
    inv  = gf_mul(x127, x127);
  end

  assign dout = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key expansion streaming NR+1 round keys over a valid/ready handshake.
// Optional macro AES_KEYEXP_STORE_EN adds an 11-entry round-key store with a read port.
//
// state | meaning
// IDLE  | waiting for start; key_in captured as round key 0 on start
// EMIT  | presenting rk_idx/rk_out, advancing on each transfer
// FIN   | one-cycle done pulse after the final key transfer
module aes_key_expand
  import aes_key_expand_pkg::*;
#(
  parameter int NR = NR_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [3:0]   rk_idx,
  output logic [127:0] rk_out,
  output logic         busy,
`ifdef AES_KEYEXP_STORE_EN
  output logic         done,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
`else
  output logic         done
`endif
);

  typedef enum logic [1:0] {IDLE, EMIT, FIN} state_t;

  localparam logic [3:0] LAST = 4'(NR);

  state_t    state;
  aes_word_t w0, w1, w2, w3, w4, w5, w6, w7, rot, sub;

  assign w0  = rk_out[127:96];
  assign w1  = rk_out[95:64];
  assign w2  = rk_out[63:32];
  assign w3  = rk_out[31:0];
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sub
    aes_sbox u_sbox (.din(rot[8*i +: 8]), .dout(sub[8*i +: 8]));
  end

  assign w4 = w0 ^ sub ^ {rcon(rk_idx + 4'd1), 24'h0};
  assign w5 = w1 ^ w4;
  assign w6 = w2 ^ w5;
  assign w7 = w3 ^ w6;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rk_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rk_idx   <= 4'd0;
      rk_out   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rk_out   <= key_in;
            rk_idx   <= 4'd0;
            rk_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= EMIT;
          end
        end
        EMIT: begin
          if (rk_valid && rk_ready) begin
            if (rk_idx == LAST) begin
              rk_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= FIN;
            end else begin
              rk_out <= {w4, w5, w6, w7};
              rk_idx <= rk_idx + 4'd1;
            end
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AES_KEYEXP_STORE_EN
  logic [127:0] key_store [0:10];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 11; i++) key_store[i] <= '0;
    end else if (rk_valid && rk_ready) begin
      key_store[rk_idx] <= rk_out;
    end
  end

  assign rd_key = (rd_idx <= LAST) ? key_store[rd_idx] : '0;
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: FIPS-197 schedule model plus directed scenarios.
module tb_aes_key_expand;

  localparam int NR = 10;
  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1    = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic         rk_ready = 1'b1;
  logic         rk_valid, busy, done;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;

  logic         start1 = 1'b0;
  logic [127:0] key_in1 = '0;
  logic         rk_ready1 = 1'b1;
  logic         rk_valid1, busy1, done1;
  logic [3:0]   rk_idx1;
  logic [127:0] rk_out1;

`ifdef AES_KEYEXP_STORE_EN
  logic [3:0]   rd_idx = 4'd0;
  logic [127:0] rd_key;
  logic [3:0]   rd_idx1 = 4'd0;
  logic [127:0] rd_key1;
`endif

  always #5 clk = ~clk;

  aes_key_expand #(.NR(NR)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_idx(rk_idx), .rk_out(rk_out),
    .busy(busy),
`ifdef AES_KEYEXP_STORE_EN
    .done(done), .rd_idx(rd_idx), .rd_key(rd_key)
`else
    .done(done)
`endif
  );

  aes_key_expand #(.NR(1)) dut_nr1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .key_in(key_in1),
    .rk_valid(rk_valid1), .rk_ready(rk_ready1), .rk_idx(rk_idx1), .rk_out(rk_out1),
    .busy(busy1),
`ifdef AES_KEYEXP_STORE_EN
    .done(done1), .rd_idx(rd_idx1), .rd_key(rd_key1)
`else
    .done(done1)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // ---------------- reference model (FIPS-197 word-recursive schedule) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 0; aa = a; bb = b;
    while (bb != 0) begin
      if (bb[0]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_m(input logic [7:0] x);
    logic [7:0] b;
    b = 8'h00;
    for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) b = 8'(y);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  logic [127:0] m_keys [0:10];

  task automatic compute_schedule(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m(t[31:24]), sbox_m(t[23:16]), sbox_m(t[15:8]), sbox_m(t[7:0])};
        t[31:24] = t[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 11; k++) m_keys[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  // ---------------- per-cycle compare against the model ----------------
  logic         m_valid = 0, m_busy = 0, m_done = 0;
  int           m_idx = 0, m_cyc = 0, xfers = 0, done_cyc = -1;
  logic         stall_prev = 0;
  logic [127:0] held_key;
  logic [3:0]   held_idx;
  logic [127:0] seen [0:15];

  initial begin
    logic nd;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_ctrl", {rk_valid, busy, done, rk_idx}, '0);
        chk("rst_key", rk_out, '0);
        m_valid = 0; m_busy = 0; m_done = 0; m_idx = 0; stall_prev = 0;
      end else begin
        m_cyc++;
        chk("valid", rk_valid, m_valid);
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        if (m_valid) begin
          chk("idx", rk_idx, m_idx);
          chk("key", rk_out, m_keys[m_idx]);
          seen[rk_idx] = rk_out;
        end
        if (stall_prev) begin
          chk("stall_key", rk_out, held_key);
          chk("stall_idx", rk_idx, held_idx);
        end
        if (done) done_cyc = m_cyc;
        stall_prev = m_valid && !rk_ready;
        held_key = rk_out;
        held_idx = rk_idx;
        nd = 0;
        if (m_valid && rk_ready) begin
          xfers++;
          if (m_idx == NR) begin
            m_valid = 0; m_busy = 0; nd = 1;
          end else begin
            m_idx++;
          end
        end else if (!m_busy && !m_done && start) begin
          compute_schedule(key_in);
          m_valid = 1; m_busy = 1; m_idx = 0; m_cyc = 0; xfers = 0; done_cyc = -1;
        end
        m_done = nd;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic do_start(input logic [127:0] key);
    @(posedge clk); #1;
    start = 1'b1; key_in = key;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done) timeout_fail(name);
    @(negedge clk);
  endtask

  task automatic wait_idx(input logic [3:0] idx, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rk_valid && rk_idx == idx) && n < 200);
    if (!(rk_valid && rk_idx == idx)) timeout_fail(name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Full run with rk_ready held high
    do_start(KEY_A);
    wait_done("t1_wait_done");
    chk("t1_done_cycle", 128'(done_cyc), 128'd12);
    chk("t1_xfers", 128'(xfers), 128'd11);
    chk("t1_idx0", seen[0], KEY_A);
    chk("t1_idx1", seen[1], K1);
    chk("t1_idx10", seen[10], K10);
    chk("model_k1", m_keys[1], K1);
    chk("model_k10", m_keys[10], K10);
`ifdef AES_KEYEXP_STORE_EN
    rd_idx = 4'd10; #1;
    chk("store_idx10", rd_key, K10);
    rd_idx = 4'd12; #1;
    chk("store_idx12", rd_key, '0);
    rd_idx = 4'd0; #1;
    chk("store_idx0", rd_key, KEY_A);
`endif

    // rk_ready toggling 1/0
    do_start(KEY_A);
    n = 0;
    while (!done && n < 200) begin
      @(posedge clk); #1;
      rk_ready = ~rk_ready;
      @(negedge clk);
      n++;
    end
    if (!done) timeout_fail("t2_wait_done");
    rk_ready = 1'b1;
    @(negedge clk);
    chk("t2_xfers", 128'(xfers), 128'd11);
    chk("t2_idx10", seen[10], K10);

    // start pulsed mid-run with a different key
    do_start(KEY_A);
    wait_idx(4'd4, "t3_wait_idx4");
    #2 start = 1'b1; key_in = KEY_B;
    @(posedge clk); #1 start = 1'b0;
    wait_done("t3_wait_done");
    chk("t3_xfers", 128'(xfers), 128'd11);
    chk("t3_idx10", seen[10], K10);

    // Async reset at idx 6, then restart
    do_start(KEY_B);
    wait_idx(4'd6, "t4_wait_idx6");
    #2 rst_n = 1'b0;
    #1;
    chk("t4_async_valid", rk_valid, 1'b0);
    chk("t4_async_busy", busy, 1'b0);
    chk("t4_async_idx", rk_idx, 4'd0);
    chk("t4_async_key", rk_out, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    do_start(KEY_B);
    wait_done("t4_wait_done");
    chk("t4_xfers", 128'(xfers), 128'd11);
    chk("t4_idx0", seen[0], KEY_B);
    chk("t4_idx10", seen[10], m_keys[10]);

    // NR=1 instance
    @(posedge clk); #1;
    start1 = 1'b1; key_in1 = KEY_A;
    @(posedge clk); #1 start1 = 1'b0;
    @(negedge clk);
    chk("nr1_valid0", rk_valid1, 1'b1);
    chk("nr1_idx0", rk_idx1, 4'd0);
    chk("nr1_key0", rk_out1, KEY_A);
    @(negedge clk);
    chk("nr1_idx1", rk_idx1, 4'd1);
    chk("nr1_key1", rk_out1, K1);
    @(negedge clk);
    chk("nr1_done", done1, 1'b1);
    chk("nr1_valid_off", rk_valid1, 1'b0);
    chk("nr1_busy_off", busy1, 1'b0);
    @(negedge clk);
    chk("nr1_done_pulse", done1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
